// File: rtl/branch_unit.sv
// Branch-decision block of the RV32I core: evaluates conditional-branch compares
// and unconditional jumps, registering the PC-select decision with one clock of latency.
module branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  BrOp,
  output logic        NextPCSrc
);

  // RISC-V funct3 encodings carried in BrOp[2:0] for conditional branches
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_t;

  logic    w_eq;
  logic    w_lt_s;
  logic    w_lt_u;
  funct3_t w_funct3;
  logic    taken_d;

  assign w_eq     = (rs1 == rs2);
  assign w_lt_s   = ($signed(rs1) < $signed(rs2));
  assign w_lt_u   = (rs1 < rs2);
  assign w_funct3 = funct3_t'(BrOp[2:0]);

  // Unknown or reserved codes fall through to not-taken
  always_comb begin
    taken_d = 1'b0;
    if (BrOp[4] == 1'b1) begin
      taken_d = 1'b1;
    end else if (BrOp[3] == 1'b1) begin
      case (w_funct3)
        F3_BEQ:  taken_d = w_eq;
        F3_BNE:  taken_d = ~w_eq;
        F3_BLT:  taken_d = w_lt_s;
        F3_BGE:  taken_d = ~w_lt_s;
        F3_BLTU: taken_d = w_lt_u;
        F3_BGEU: taken_d = ~w_lt_u;
        default: taken_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      NextPCSrc <= 1'b0;
    end else begin
      NextPCSrc <= taken_d;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit: compare ops, boundary operands,
// jumps, reserved codes, synchronous reset behaviour and one-cycle latency.
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  BrOp;
  logic        NextPCSrc;

  int testsRun;
  int testsFailed;

  localparam logic [4:0] OP_NONE = 5'b00000;
  localparam logic [4:0] OP_JUMP = 5'b10000;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_R2   = 5'b01010;
  localparam logic [4:0] OP_R3   = 5'b01011;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BGE  = 5'b01101;
  localparam logic [4:0] OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111;

  branch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1       (rs1),
    .rs2       (rs2),
    .BrOp      (BrOp),
    .NextPCSrc (NextPCSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive operands, let one rising edge capture them, then sample 1 ns later
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    rs1  = a;
    rs2  = b;
    BrOp = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    rs1   = 32'd0;
    rs2   = 32'd0;
    BrOp  = OP_NONE;
    #2;

    // Reset overrides a jump request
    applyStimulus(32'd0, 32'd0, OP_JUMP);
    checkOutput("reset_jump", NextPCSrc, 1'b0);
    applyStimulus(32'd0, 32'd0, OP_JUMP);
    checkOutput("reset_hold", NextPCSrc, 1'b0);
    rst_n = 1'b1;
    applyStimulus(32'd0, 32'd0, OP_JUMP);
    checkOutput("reset_release", NextPCSrc, 1'b1);

    // Pulse reset low strictly between edges: output must not change
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    checkOutput("reset_glitch_now", NextPCSrc, 1'b1);
    applyStimulus(32'd0, 32'd0, OP_JUMP);
    checkOutput("reset_glitch_edge", NextPCSrc, 1'b1);

    // Latency: change right after an edge, output holds until the next edge
    BrOp = OP_NONE;
    #3;
    checkOutput("latency_hold", NextPCSrc, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("latency_update", NextPCSrc, 1'b0);

    // Equality pair
    applyStimulus(32'd5, 32'd5, OP_BEQ);
    checkOutput("beq_equal", NextPCSrc, 1'b1);
    applyStimulus(32'd5, 32'd7, OP_BNE);
    checkOutput("bne_differ", NextPCSrc, 1'b1);
    applyStimulus(32'd5, 32'd7, OP_BEQ);
    checkOutput("beq_differ", NextPCSrc, 1'b0);
    applyStimulus(32'd5, 32'd5, OP_BNE);
    checkOutput("bne_equal", NextPCSrc, 1'b0);

    // Signed compares (-5 = FFFFFFFB, -1 = FFFFFFFF)
    applyStimulus(32'hFFFF_FFFB, 32'd3, OP_BLT);
    checkOutput("blt_neg_pos", NextPCSrc, 1'b1);
    applyStimulus(32'd10, 32'hFFFF_FFFF, OP_BGE);
    checkOutput("bge_pos_neg", NextPCSrc, 1'b1);
    applyStimulus(32'd10, 32'hFFFF_FFFF, OP_BLT);
    checkOutput("blt_pos_neg", NextPCSrc, 1'b0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, OP_BGE);
    checkOutput("bge_equal_min", NextPCSrc, 1'b1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, OP_BLT);
    checkOutput("blt_equal_min", NextPCSrc, 1'b0);

    // Boundary operands: signed vs unsigned disagree
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, OP_BLT);
    checkOutput("blt_min_max", NextPCSrc, 1'b1);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, OP_BLTU);
    checkOutput("bltu_min_max", NextPCSrc, 1'b0);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, OP_BGEU);
    checkOutput("bgeu_min_max", NextPCSrc, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, OP_BLT);
    checkOutput("blt_m1_zero", NextPCSrc, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, OP_BGE);
    checkOutput("bge_m1_zero", NextPCSrc, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, OP_BGEU);
    checkOutput("bgeu_m1_zero", NextPCSrc, 1'b1);

    // Unsigned compares
    applyStimulus(32'h0000_0001, 32'hFFFF_FF00, OP_BLTU);
    checkOutput("bltu_small_big", NextPCSrc, 1'b1);
    applyStimulus(32'hFFFF_FF00, 32'h0000_0001, OP_BGEU);
    checkOutput("bgeu_big_small", NextPCSrc, 1'b1);
    applyStimulus(32'hFFFF_FF00, 32'h0000_0001, OP_BLTU);
    checkOutput("bltu_big_small", NextPCSrc, 1'b0);
    applyStimulus(32'h1234_5678, 32'h1234_5678, OP_BGEU);
    checkOutput("bgeu_equal", NextPCSrc, 1'b1);

    // Unconditional, no-branch and reserved codes
    applyStimulus(32'd1, 32'd2, OP_JUMP);
    checkOutput("jump_10000", NextPCSrc, 1'b1);
    applyStimulus(32'd1, 32'd2, 5'b11111);
    checkOutput("jump_11111", NextPCSrc, 1'b1);
    applyStimulus(32'd123, 32'd456, OP_NONE);
    checkOutput("no_branch", NextPCSrc, 1'b0);
    applyStimulus(32'd7, 32'd7, 5'b00111);
    checkOutput("no_branch_f3", NextPCSrc, 1'b0);
    applyStimulus(32'd7, 32'd7, OP_R2);
    checkOutput("reserved_010", NextPCSrc, 1'b0);
    applyStimulus(32'd1, 32'd9, OP_R3);
    checkOutput("reserved_011", NextPCSrc, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
